// File: rtl/exp_fade.sv
// Exponential LED fade controller: walks a linear brightness index toward a target,
// one step per (rate+1) PWM periods, and publishes an exponential duty word at period edges.
module exp_fade (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] target,
  input  logic [3:0] rate,
  input  logic [7:0] ramp,
  output logic [7:0] value,
  output logic [7:0] level,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] UP   = 2'd1;
  localparam logic [1:0] DOWN = 2'd2;

  // Piecewise-exponential map: top 3 bits select the octave, low 5 bits the mantissa.
  function automatic logic [7:0] exp_map(input logic [7:0] lin);
    logic [12:0] t;
    t = 13'({1'b1, lin[4:0]}) << lin[7:5];
    t = (t >> 5) - 13'd1;
    return t[7:0];
  endfunction

  logic [1:0] state_q, state_d;
  logic [3:0] div_cnt_q, div_cnt_d;
  logic [7:0] level_q, level_d;
  logic [7:0] value_q, value_d;
  logic       done_q, done_d;
  logic       pb;
  logic       active;

  assign pb     = (ramp == 8'hFF);
  assign active = (state_q != IDLE);

  // Direction comes from the live target so a target change in the boundary cycle
  // steers that very step; the compares also keep level from passing target or wrapping.
  always_comb begin
    level_d   = level_q;
    div_cnt_d = div_cnt_q;
    if (!active) begin
      div_cnt_d = 4'd0;
    end else if (pb) begin
      if (div_cnt_q == rate) begin
        div_cnt_d = 4'd0;
        if (target > level_q) begin
          level_d = level_q + 8'd1;
        end else if (target < level_q) begin
          level_d = level_q - 8'd1;
        end
      end else begin
        div_cnt_d = div_cnt_q + 4'd1;
      end
    end
  end

  always_comb begin
    if (target > level_d) begin
      state_d = UP;
    end else if (target < level_d) begin
      state_d = DOWN;
    end else begin
      state_d = IDLE;
    end
    value_d = pb ? exp_map(level_d) : value_q;
    done_d  = active && (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      div_cnt_q <= 4'd0;
      level_q   <= 8'd0;
      value_q   <= 8'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      level_q   <= level_d;
      value_q   <= value_d;
      done_q    <= done_d;
    end
  end

  assign value = value_q;
  assign level = level_q;
  assign busy  = active;
  assign done  = done_q;

endmodule

// File: tb/tb_exp_fade.sv
// Directed bench for exp_fade: scoreboard of expected values pushed at stimulus time,
// popped and compared with immediate assertions when the DUT output is sampled.
module tb_exp_fade;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] target;
  logic [3:0] rate;
  logic [7:0] ramp = 8'd0;
  logic [7:0] ramp_step = 8'd1;
  logic [7:0] value;
  logic [7:0] level;
  logic       busy;
  logic       done;

  exp_fade dut (
    .clk    (clk),
    .reset  (reset),
    .target (target),
    .rate   (rate),
    .ramp   (ramp),
    .value  (value),
    .level  (level),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Ramp generator: step 1 gives the real 256-clock period, step 32 a compressed one
  // (steps are only changed right at 8'hFF so every period still passes through 8'hFF).
  initial begin
    forever begin
      @(posedge clk);
      #1 ramp = ramp + ramp_step;
    end
  end

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  total = 0;
  int  bad = 0;
  int  done_cnt = 0;
  int  done_double = 0;
  int  hold_viol = 0;
  logic edge_ok = 1'b1;
  logic done_prev = 1'b0;
  logic [7:0] value_prev;
  logic [7:0] level_prev;

  always @(posedge clk) edge_ok = (ramp == 8'hFF) || reset;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (done === 1'b1 && done_prev === 1'b1) done_double++;
    done_prev = done;
    if (!edge_ok && (value !== value_prev || level !== level_prev)) hold_viol++;
    value_prev = value;
    level_prev = level;
  end

  function automatic logic [7:0] ref_exp(input int lin);
    int e, m, v;
    e = lin / 32;
    m = lin % 32;
    v = ((32 + m) * (1 << e)) / 32 - 1;
    return v[7:0];
  endfunction

  task automatic push(input string tag, input logic [7:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [7:0] obs);
    sb_t e;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic wait_pb_cycle();
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (ramp == 8'hFF) seen = 1'b1;
    end
    total++;
    assert (seen) else begin
      bad++;
      $error("FAIL pb_timeout observed=0 expected=1");
    end
  endtask

  task automatic pb_edge();
    wait_pb_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pb_edge_target(input logic [7:0] t);
    wait_pb_cycle();
    target = t;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_step(input logic [7:0] s);
    wait_pb_cycle();
    ramp_step = s;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_done_cnt(input int exp);
    #1;
    push("done_count", exp[7:0]);
    check(done_cnt[7:0]);
  endtask

  initial begin
    int base;
    logic [7:0] prev_v;
    logic [7:0] pts [4];
    logic [7:0] pvs [4];
    pts[0] = 8'h20; pvs[0] = 8'd1;
    pts[1] = 8'h80; pvs[1] = 8'd15;
    pts[2] = 8'hE0; pvs[2] = 8'd127;
    pts[3] = 8'hFF; pvs[3] = 8'd251;

    reset  = 1'b1;
    target = 8'h00;
    rate   = 4'd0;
    repeat (3) @(negedge clk);

    // Reset state
    push("rst_level", 8'h00); push("rst_value", 8'h00);
    push("rst_busy", 8'h00);  push("rst_done", 8'h00);
    check(level); check(value); check({7'b0, busy}); check({7'b0, done});

    // Idle with target 0 across two full periods
    reset = 1'b0;
    pb_edge();
    pb_edge();
    push("idle_level", 8'h00); push("idle_value", 8'h00); push("idle_busy", 8'h00);
    check(level); check(value); check({7'b0, busy});
    check_done_cnt(0);

    // Full sweep 0 -> 255 at rate 0
    set_step(8'd32);
    target = 8'hFF;
    @(negedge clk);
    push("sweep_busy", 8'h01);
    check({7'b0, busy});
    prev_v = value;
    for (int i = 1; i < 256; i++) begin
      pb_edge();
      push("sweep_level", i[7:0]);
      push("sweep_value", ref_exp(i));
      check(level);
      check(value);
      total++;
      assert (value >= prev_v) else begin
        bad++;
        $error("FAIL sweep_monotonic observed=%0d expected>=%0d", value, prev_v);
      end
      prev_v = value;
      for (int p = 0; p < 4; p++) begin
        if (pts[p] == i[7:0]) begin
          push("map_point", pvs[p]);
          check(value);
        end
      end
      if (i == 255) begin
        push("sweep_done_pulse", 8'h01);
        check({7'b0, done});
      end
    end
    @(negedge clk);
    push("sweep_done_low", 8'h00); push("sweep_busy_low", 8'h00);
    check({7'b0, done}); check({7'b0, busy});
    check_done_cnt(1);

    // Reversal mid-fade in a boundary cycle
    reset  = 1'b1;
    target = 8'h80;
    rate   = 4'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    base = done_cnt;
    for (int i = 0; i < 8'h40; i++) pb_edge();
    push("rev_level_up", 8'h40);
    check(level);
    pb_edge_target(8'h10);
    push("rev_first_down", 8'h3F); push("rev_busy", 8'h01); push("rev_no_done", 8'h00);
    check(level); check({7'b0, busy}); check({7'b0, done});
    for (int i = 0; i < 8'h2E; i++) pb_edge();
    push("rev_level_mid", 8'h11); push("rev_busy_mid", 8'h01);
    check(level); check({7'b0, busy});
    check_done_cnt(base);
    pb_edge();
    push("rev_level_end", 8'h10); push("rev_done_pulse", 8'h01);
    check(level); check({7'b0, done});
    check_done_cnt(base + 1);

    // Reset mid-fade at level 0x55, asserted in a boundary cycle
    reset  = 1'b1;
    target = 8'hFF;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    base = done_cnt;
    for (int i = 0; i < 8'h55; i++) pb_edge();
    push("abort_level", 8'h55); push("abort_value", ref_exp(8'h55));
    check(level); check(value);
    wait_pb_cycle();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    push("abort_rst_level", 8'h00); push("abort_rst_value", 8'h00);
    push("abort_rst_busy", 8'h00);  push("abort_rst_done", 8'h00);
    check(level); check(value); check({7'b0, busy}); check({7'b0, done});

    // Slow fade to 0x80 at rate 3, real 256-clock periods for the first steps
    target = 8'h80;
    rate   = 4'd3;
    set_step(8'd1);
    reset = 1'b0;
    @(negedge clk);
    push("slow_busy", 8'h01);
    check({7'b0, busy});
    check_done_cnt(base);
    for (int i = 0; i < 3; i++) pb_edge();
    push("slow_level_3pb", 8'h00);
    check(level);
    pb_edge();
    push("slow_level_4pb", 8'h01); push("slow_value_4pb", ref_exp(1));
    check(level); check(value);
    for (int i = 0; i < 4; i++) pb_edge();
    push("slow_level_8pb", 8'h02);
    check(level);
    set_step(8'd32);
    for (int i = 0; i < 503; i++) pb_edge();
    push("slow_level_end", 8'h80); push("slow_value_end", 8'd15);
    push("slow_done_pulse", 8'h01);
    check(level); check(value); check({7'b0, done});
    @(negedge clk);
    push("slow_busy_low", 8'h00);
    check({7'b0, busy});
    check_done_cnt(base + 1);

    #1;
    push("hold_violations", 8'h00); push("done_double", 8'h00);
    check(hold_viol[7:0]); check(done_double[7:0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exp_fade.md
EXP_FADE -- requirements
Module: exp_fade

Interface
REQ-001 Parameter: none; all widths fixed as listed below.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 target  input  8  requested linear brightness index, 0..255.
REQ-005 rate  input  4  fade speed; one index step every (rate+1) PWM periods.
REQ-006 ramp  input  8  free-running PWM ramp from the upstream ramp generator.
REQ-007 value  output  8  exponential duty word; drives the PWM channel compare input.
REQ-008 level  output  8  current linear index (registered).
REQ-009 busy  output  1  high while state is UP or DOWN.
REQ-010 done  output  1  single-cycle pulse when a fade completes.

Function
REQ-011 Period boundary event (PB) SHALL be defined as a cycle with ramp == 8'hFF.
REQ-012 State machine SHALL have states IDLE, UP, DOWN, held in a registered state variable.
REQ-013 Each cycle, next state = UP if target > level_next, DOWN if target < level_next, else IDLE; level_next is the level value loaded on that edge.
REQ-014 A 4-bit period counter div_cnt SHALL be held at 0 while state is IDLE.
REQ-015 On PB with state UP or DOWN: if div_cnt == rate, div_cnt <= 0 and level steps by one toward target; else div_cnt <= div_cnt + 1.
REQ-016 Step direction SHALL use the target sampled in the PB cycle, not the registered state, so a target change in the PB cycle takes effect on that step.
REQ-017 Level SHALL never step past target, never wrap below 0 or above 255.
REQ-018 If target equals level in a PB cycle, no step occurs, even if state is UP or DOWN.
REQ-019 Mapping: with e = L[7:5], m = L[4:0], exp(L) = ((({1'b1,m}) << e) >> 5) - 1, computed at 13-bit width, result truncated to 8 bits.
REQ-020 Required mapping points: exp(0x00)=0, exp(0x20)=1, exp(0x80)=15, exp(0xE0)=127, exp(0xFF)=251; mapping is monotonic non-decreasing.
REQ-021 value SHALL be registered and SHALL load exp(level_next) only on PB edges, so duty never changes mid PWM period.
REQ-022 Outside PB, value and level SHALL hold.
REQ-023 done SHALL pulse high for exactly one cycle on any registered transition from UP or DOWN into IDLE, including when target moves onto the current level.
REQ-024 rate changes mid-fade SHALL take effect at the next PB compare; if div_cnt > new rate, div_cnt counts up and wraps 15->0 without stepping; the compare then fires on reaching rate.
REQ-025 Target reversal mid-fade: state follows REQ-013; div_cnt is not cleared.

Reset
REQ-026 While reset is high on a clock edge: level=0, value=0, state=IDLE, div_cnt=0, busy=0, done=0.
REQ-027 Reset SHALL override PB and target in the same cycle; reset mid-fade aborts the fade without a done pulse.
REQ-028 After reset deasserts, a nonzero target starts a fade per REQ-013 on the next edge.

Verification
REQ-029 Bench ramp: free-running 0..255 counter, 256 clk per period.
REQ-030 Reset, target=0 -> value=0, level=0, busy=0, done never pulses.
REQ-031 target=0xFF, rate=0 from level 0 -> level +1 per PB; level=0xFF and value=251 after 255 PBs; one done pulse; busy low after that.
REQ-032 target=0x80, rate=3 from level 0 -> level +1 every 4th PB; value=15 after 512 PBs; value constant between PBs.
REQ-033 Fade up to 0x40, then target=0x10 applied in a PB cycle -> that PB steps down, state=DOWN, busy stays high, no done until level=0x10.
REQ-034 Reset asserted mid-fade at level 0x55 -> next edge level=0, value=0, state IDLE, no done pulse.
REQ-035 Sweep level 0..255 at rate=0 -> each value matches REQ-019 and is monotonic non-decreasing.
